logic_ram_write_sched: RTL and testbench

- Controller that owns the single write port of a register-built multi-read-port RAM.
- After reset it sequences an initialization sweep that writes INIT_VALUE to every address, then shares the write port among NUM_WRITERS requesters with round-robin arbitration.
- Sits between pipeline write sources and the RAM's wren/wraddr/wrdata inputs; read ports are untouched.

---
 rtl/logic_ram_write_sched_if.sv | 35 +++
 rtl/logic_ram_write_sched.sv | 147 ++++++++++++++
 tb/tb_logic_ram_write_sched.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_ram_write_sched_if.sv
// -----------------------------------------------------------------------------
// logic_ram_write_sched_if
// Bundle of write-request signals between NUM_WRITERS pipeline write sources
// and the RAM write scheduler. The signal names follow the scheduler's view:
// *_in are driven by the writers, *_out by the scheduler.
//   req_valid_in  [NUM_WRITERS]             per-writer request valid
//   req_ready_out [NUM_WRITERS]             per-writer accept (one-hot or zero)
//   req_addr_in   [NUM_WRITERS][ADDR_WIDTH] per-writer write address
//   req_data_in   [NUM_WRITERS][DATA_WIDTH] per-writer write data
// Modports: master = writer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface logic_ram_write_sched_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_WRITERS = 3
);
  logic [NUM_WRITERS-1:0]                 req_valid_in;
  logic [NUM_WRITERS-1:0]                 req_ready_out;
  logic [NUM_WRITERS-1:0][ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_WRITERS-1:0][DATA_WIDTH-1:0] req_data_in;

  modport master (
    output req_valid_in,
    output req_addr_in,
    output req_data_in,
    input  req_ready_out
  );

  modport slave (
    input  req_valid_in,
    input  req_addr_in,
    input  req_data_in,
    output req_ready_out
  );
endinterface

// File: rtl/logic_ram_write_sched.sv
// -----------------------------------------------------------------------------
// logic_ram_write_sched
// Owner of the single write port of a register-built multi-read-port RAM.
// After reset it sweeps INIT_VALUE into every address 0..DEPTH-1, then shares
// the write port among NUM_WRITERS requesters with round-robin arbitration.
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   req            write-request bundle (slave side)
//   wren_out       registered RAM write enable
//   wraddr_out     registered RAM write address
//   wrdata_out     registered RAM write data
//   init_done_out  high from the cycle after the last init write until reset
//   addr_err_out   sticky: an out-of-range request was accepted and dropped
//
// state  | meaning
// S_INIT | sweeping INIT_VALUE into addresses 0..DEPTH-1, no requests accepted
// S_RUN  | round-robin arbitration of writer requests
// -----------------------------------------------------------------------------
module logic_ram_write_sched #(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 16,
  parameter int                  DEPTH       = 2**ADDR_WIDTH,
  parameter int                  NUM_WRITERS = 3,
  parameter int                  INIT_ENABLE = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  logic_ram_write_sched_if.slave  req,
  output logic                    wren_out,
  output logic [ADDR_WIDTH-1:0]   wraddr_out,
  output logic [DATA_WIDTH-1:0]   wrdata_out,
  output logic                    init_done_out,
  output logic                    addr_err_out
);

  localparam int PTR_W = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
  // One extra counter bit so DEPTH = 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_C  = DEPTH_C - (ADDR_WIDTH+1)'(1);
  localparam logic [PTR_W-1:0]    PTR_MAX = PTR_W'(NUM_WRITERS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_ENABLE != 0) ? S_INIT : S_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  int                    idx;

  // Round-robin search starting at the pointer, wrapping modulo NUM_WRITERS.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < NUM_WRITERS; off++) begin
      idx = (int'(ptr_q) + off) % NUM_WRITERS;
      if (!grant_vld && req.req_valid_in[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  // Ready depends on valid (grant), never the other way round.
  always_comb begin
    req.req_ready_out = '0;
    if (state_q == S_RUN && grant_vld)
      req.req_ready_out = NUM_WRITERS'(1) << grant_idx;
  end

  assign sel_addr = req.req_addr_in[grant_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    done_d   = done_q | (state_q == S_RUN);
    err_d    = err_q;
    case (state_q)
      S_INIT: begin
        wren_d   = 1'b1;
        wraddr_d = cnt_q[ADDR_WIDTH-1:0];
        wrdata_d = INIT_VALUE;
        cnt_d    = cnt_q + (ADDR_WIDTH+1)'(1);
        if (cnt_q == LAST_C)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (grant_vld) begin
          ptr_d = (grant_idx == PTR_MAX) ? '0 : grant_idx + PTR_W'(1);
          // Out-of-range requests are accepted but never reach the RAM.
          if ({1'b0, sel_addr} < DEPTH_C) begin
            wren_d   = 1'b1;
            wraddr_d = sel_addr;
            wrdata_d = req.req_data_in[grant_idx];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign wren_out      = wren_q;
  assign wraddr_out    = wraddr_q;
  assign wrdata_out    = wrdata_q;
  assign init_done_out = done_q;
  assign addr_err_out  = err_q;

endmodule

// File: tb/tb_logic_ram_write_sched.sv
// -----------------------------------------------------------------------------
// tb_logic_ram_write_sched
// Main DUT: DEPTH=8, ADDR_WIDTH=4, 16-bit data, INIT_VALUE=0xA5, 3 writers.
// Second DUT: DEPTH=6, ADDR_WIDTH=3, INIT_ENABLE=0, for range checking.
// Expected writes of the main DUT are queued with the cycle they must appear
// in; a monitor pops and compares whenever wren_out is high.
// -----------------------------------------------------------------------------
module tb_logic_ram_write_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- main DUT ----------------
  logic_ram_write_sched_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_WRITERS(3)) bus ();
  logic        wren, done, err;
  logic [3:0]  wraddr;
  logic [15:0] wrdata;

  logic_ram_write_sched #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(8), .NUM_WRITERS(3),
    .INIT_ENABLE(1), .INIT_VALUE(16'h00A5)
  ) dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .wren_out(wren), .wraddr_out(wraddr), .wrdata_out(wrdata),
    .init_done_out(done), .addr_err_out(err)
  );

  // ---------------- range-check DUT ----------------
  logic_ram_write_sched_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_WRITERS(3)) bus2 ();
  logic        wren2, done2, err2;
  logic [2:0]  wraddr2;
  logic [15:0] wrdata2;

  logic_ram_write_sched #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(6), .NUM_WRITERS(3),
    .INIT_ENABLE(0), .INIT_VALUE(16'h0000)
  ) dut2 (
    .clk(clk), .rst(rst2), .req(bus2.slave),
    .wren_out(wren2), .wraddr_out(wraddr2), .wrdata_out(wrdata2),
    .init_done_out(done2), .addr_err_out(err2)
  );

  // RAM with 1-cycle write fed from the main DUT's write port.
  logic [15:0] mem [0:15];
  always @(posedge clk) if (wren) mem[wraddr] <= wrdata;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL missed_write: no write seen, required addr %0h data %0h at cycle %0d", e.addr, e.data, e.cyc);
    end
    if (wren) begin
      n_cmp++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, required none", wraddr, wrdata, cyc);
      end else begin
        e = q.pop_front();
        if (wraddr !== e.addr || wrdata !== e.data) begin
          n_err++;
          $display("FAIL write_port: got addr %0h data %0h, required addr %0h data %0h (cycle %0d)",
                   wraddr, wrdata, e.addr, e.data, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present valid vector v for one cycle; exp_rdy is the hand-derived grant.
  task automatic issue(input logic [2:0] v, input logic [2:0] exp_rdy);
    bus.req_valid_in = v;
    @(negedge clk);
    chk("ready", {29'd0, bus.req_ready_out}, {29'd0, exp_rdy});
    for (int i = 0; i < 3; i++)
      if (exp_rdy[i] && bus.req_addr_in[i] < 4'd8)
        q.push_back('{cyc + 1, bus.req_addr_in[i], bus.req_data_in[i]});
    step();
    bus.req_valid_in = '0;
  endtask

  // Release reset and follow the init sweep; abort_after>0 re-asserts reset
  // after that many init writes.
  task automatic run_init(input int abort_after);
    int base, nw;
    bus.req_valid_in = '1;
    rst  = 1'b0;
    base = cyc;
    nw   = (abort_after > 0) ? abort_after : 8;
    for (int k = 0; k < nw; k++)
      q.push_back('{base + 1 + k, 4'(k), 16'h00A5});
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      chk("init_ready", {29'd0, bus.req_ready_out}, 32'd0);
      chk("init_done_low", {31'd0, done}, 32'd0);
      step();
    end
    bus.req_valid_in = '0;
    if (abort_after > 0) begin
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("abort_wren", {31'd0, wren}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      step();
    end else begin
      @(negedge clk);
      chk("done_last_write", {31'd0, done}, 32'd0);
      step();
      @(negedge clk);
      chk("done_rise", {31'd0, done}, 32'd1);
      step();
    end
  endtask

  initial begin
    bus.req_valid_in = '0;
    bus.req_addr_in  = '0;
    bus.req_data_in  = '0;
    bus2.req_valid_in = '0;
    bus2.req_addr_in  = '0;
    bus2.req_data_in  = '0;
    repeat (3) step();

    // Reset state.
    bus.req_valid_in = '1;
    @(negedge clk);
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_wraddr", {28'd0, wraddr}, 32'd0);
    chk("rst_wrdata", {16'd0, wrdata}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {29'd0, bus.req_ready_out}, 32'd0);
    step();

    // Reset mid-INIT after 3 writes, then a full sweep.
    run_init(3);
    step();
    run_init(0);
    chk("ram_init_5", {16'd0, mem[5]}, 32'h00A5);
    chk("ram_init_7", {16'd0, mem[7]}, 32'h00A5);

    // Single writer 1: addr 3, data 0x1234 (pointer 0 -> 2).
    bus.req_addr_in[1] = 4'd3; bus.req_data_in[1] = 16'h1234;
    issue(3'b010, 3'b010);
    @(negedge clk);
    chk("ram_before_write", {16'd0, mem[3]}, 32'h00A5);
    step();
    @(negedge clk);
    chk("ram_after_write", {16'd0, mem[3]}, 32'h1234);
    chk("hold_wraddr", {28'd0, wraddr}, 32'd3);
    chk("hold_wrdata", {16'd0, wrdata}, 32'h1234);
    step();

    // Pointer wrap: writer2 alone (ptr 2 -> 0), then 0&2 -> 0, then 0&2 -> 2.
    bus.req_addr_in[2] = 4'd6; bus.req_data_in[2] = 16'hBEEF;
    bus.req_addr_in[0] = 4'd1; bus.req_data_in[0] = 16'h1111;
    issue(3'b100, 3'b100);
    issue(3'b101, 3'b001);
    issue(3'b101, 3'b100);

    // Contention from pointer 0: back-to-back 0,1,2,0,1,2.
    bus.req_addr_in[1] = 4'd3; bus.req_data_in[1] = 16'h2222;
    for (int r = 0; r < 2; r++) begin
      bus.req_valid_in = 3'b111;
      issue(3'b111, 3'b001);
      issue(3'b111, 3'b010);
      issue(3'b111, 3'b100);
    end
    issue(3'b000, 3'b000);

    // Out-of-range on main DUT (addr 9 >= 8), then a normal write.
    bus.req_addr_in[0] = 4'd9; bus.req_data_in[0] = 16'h9999;
    issue(3'b001, 3'b001);
    @(negedge clk);
    chk("err_set", {31'd0, err}, 32'd1);
    step();
    bus.req_addr_in[1] = 4'd7; bus.req_data_in[1] = 16'h7777;
    issue(3'b011, 3'b010);
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    step();

    // Reset mid-RUN drops the in-flight accept.
    bus.req_valid_in = 3'b001;
    bus.req_addr_in[0] = 4'd2;
    rst = 1'b1;
    step();
    bus.req_valid_in = '0;
    @(negedge clk);
    chk("runrst_wren", {31'd0, wren}, 32'd0);
    chk("runrst_err", {31'd0, err}, 32'd0);
    chk("runrst_done", {31'd0, done}, 32'd0);
    step();

    // Range-check DUT: DEPTH=6, no init sweep.
    rst2 = 1'b0;
    @(negedge clk);
    chk("d2_done_low", {31'd0, done2}, 32'd0);
    step();
    @(negedge clk);
    chk("d2_done_high", {31'd0, done2}, 32'd1);
    step();
    bus2.req_valid_in = 3'b001; bus2.req_addr_in[0] = 3'd7; bus2.req_data_in[0] = 16'h0077;
    @(negedge clk);
    chk("d2_oor_ready", {29'd0, bus2.req_ready_out}, 32'b001);
    step();
    bus2.req_valid_in = '0;
    @(negedge clk);
    chk("d2_oor_wren", {31'd0, wren2}, 32'd0);
    chk("d2_err_set", {31'd0, err2}, 32'd1);
    step();
    bus2.req_valid_in = 3'b010; bus2.req_addr_in[1] = 3'd2; bus2.req_data_in[1] = 16'h0202;
    @(negedge clk);
    chk("d2_ready1", {29'd0, bus2.req_ready_out}, 32'b010);
    step();
    bus2.req_valid_in = 3'b100; bus2.req_addr_in[2] = 3'd5; bus2.req_data_in[2] = 16'h0505;
    @(negedge clk);
    chk("d2_wren_a2", {31'd0, wren2}, 32'd1);
    chk("d2_wraddr_a2", {29'd0, wraddr2}, 32'd2);
    chk("d2_wrdata_a2", {16'd0, wrdata2}, 32'h0202);
    chk("d2_err_sticky", {31'd0, err2}, 32'd1);
    chk("d2_ready2", {29'd0, bus2.req_ready_out}, 32'b100);
    step();
    bus2.req_valid_in = '0;
    @(negedge clk);
    chk("d2_wren_last", {31'd0, wren2}, 32'd1);
    chk("d2_wraddr_last", {29'd0, wraddr2}, 32'd5);
    step();
    rst2 = 1'b1;
    step();
    @(negedge clk);
    chk("d2_rst_err", {31'd0, err2}, 32'd0);
    chk("d2_rst_done", {31'd0, done2}, 32'd0);

    repeat (3) step();
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++; n_err++;
    $display("FAIL timeout: bench did not complete, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
